// File: rtl/cnt_sweep_driver.sv
// ---------------------------------------------------------------------------
// cnt_sweep_driver : load / count-up / count-down sweep source for a 4-bit
// up/down counter. SWEEP_CHECK_EN builds the q-tracking compare (err).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnt_sweep_driver #(
  parameter int STEP_W = 8,
  parameter int CO_W   = 8
) (
  input  logic              clk,
  input  logic              mr_n,
  input  logic              start,
  input  logic [3:0]        cfg_start,
  input  logic [STEP_W-1:0] cfg_up,
  input  logic [STEP_W-1:0] cfg_down,
  output logic              cnt_load,
  output logic              cnt_en,
  output logic              cnt_up_down,
  output logic [3:0]        cnt_d,
  input  logic [3:0]        cnt_q,
  input  logic              cnt_co,
  output logic              busy,
  output logic              done,
  output logic [CO_W-1:0]   co_cnt,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] sh_up, sh_down;
  logic [STEP_W-1:0] step, step_nxt;
  logic              cap;
  logic              load_nxt, en_nxt, ud_nxt, busy_nxt, done_nxt;
  logic [3:0]        d_nxt;
  logic [CO_W-1:0]   co_nxt;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    d_nxt     = cnt_d;
    ud_nxt    = cnt_up_down;
    co_nxt    = co_cnt;
    cap       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cap       = 1'b1;
          d_nxt     = cfg_start;
        end
      end
      S_LOAD: begin
        if (sh_up != '0) begin
          state_nxt = S_UP;
          step_nxt  = sh_up;
        end else if (sh_down != '0) begin
          state_nxt = S_DOWN;
          step_nxt  = sh_down;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_UP: begin
        step_nxt = step - STEP_W'(1);
        if (step == STEP_W'(1)) begin
          if (sh_down != '0) begin
            state_nxt = S_DOWN;
            step_nxt  = sh_down;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_DOWN: begin
        step_nxt = step - STEP_W'(1);
        if (step == STEP_W'(1)) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // co is only meaningful while the counter was actually commanded to count
    if (cnt_en && cnt_co && (co_cnt != {CO_W{1'b1}})) co_nxt = co_cnt + CO_W'(1);
    if (cap) co_nxt = '0;

    // Registered outputs are a function of the state being entered
    load_nxt = (state_nxt != S_LOAD);
    en_nxt   = (state_nxt == S_UP) || (state_nxt == S_DOWN);
    if (state_nxt == S_UP)   ud_nxt = 1'b0;
    if (state_nxt == S_DOWN) ud_nxt = 1'b1;
    busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_UP) || (state_nxt == S_DOWN);
    done_nxt = (state_nxt == S_FIN);
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state       <= S_IDLE;
      step        <= '0;
      sh_up       <= '0;
      sh_down     <= '0;
      cnt_load    <= 1'b1;
      cnt_en      <= 1'b0;
      cnt_up_down <= 1'b0;
      cnt_d       <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      co_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      step        <= step_nxt;
      cnt_load    <= load_nxt;
      cnt_en      <= en_nxt;
      cnt_up_down <= ud_nxt;
      cnt_d       <= d_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      co_cnt      <= co_nxt;
      if (cap) begin
        sh_up   <= cfg_up;
        sh_down <= cfg_down;
      end
    end
  end

`ifdef SWEEP_CHECK_EN
  logic [3:0] sh_start;
  logic [3:0] exp_q;
  logic       chk;
  logic       err_r;

  // exp advances on the same edge the counter acts on a command, so during
  // the following cycle (chk=1) cnt_q must equal exp_q.
  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      sh_start <= 4'd0;
      exp_q    <= 4'd0;
      chk      <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (cap) sh_start <= cfg_start;
      chk <= (state == S_LOAD) || (state == S_UP) || (state == S_DOWN);
      case (state)
        S_LOAD:  exp_q <= sh_start;
        S_UP:    exp_q <= exp_q + 4'd1;
        S_DOWN:  exp_q <= exp_q - 4'd1;
        default: exp_q <= exp_q;
      endcase
      if (cap)                           err_r <= 1'b0;
      else if (chk && (cnt_q != exp_q)) err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_q;
  assign unused_q = ^cnt_q;
  assign err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cnt_sweep_driver.sv
// ---------------------------------------------------------------------------
// tb_cnt_sweep_driver : directed bench for cnt_sweep_driver with a behavioural
// 4-bit counter closing the loop. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cnt_sweep_driver;

`ifdef SWEEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       mr_n;
  logic       start;
  logic [3:0] cfg_start;
  logic [7:0] cfg_up, cfg_down;
  logic       cnt_load, cnt_en, cnt_up_down;
  logic [3:0] cnt_d, cnt_q;
  logic       cnt_co;
  logic       busy, done, err;
  logic [7:0] co_cnt;

  logic [3:0] mq;
  logic       stuck;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         done_seen = 0;
  int         d0;
  int         ok;

  cnt_sweep_driver #(.STEP_W(8), .CO_W(8)) dut (
    .clk(clk), .mr_n(mr_n), .start(start), .cfg_start(cfg_start),
    .cfg_up(cfg_up), .cfg_down(cfg_down), .cnt_load(cnt_load),
    .cnt_en(cnt_en), .cnt_up_down(cnt_up_down), .cnt_d(cnt_d),
    .cnt_q(cnt_q), .cnt_co(cnt_co), .busy(busy), .done(done),
    .co_cnt(co_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Counter under drive: sync active-low load, 1-cycle latency
  always @(posedge clk or negedge mr_n) begin
    if (!mr_n)          mq <= 4'd0;
    else if (!cnt_load) mq <= cnt_d;
    else if (cnt_en)    mq <= cnt_up_down ? mq - 4'd1 : mq + 4'd1;
  end
  assign cnt_q  = stuck ? 4'd0 : mq;
  assign cnt_co = cnt_en && ((!cnt_up_down && mq == 4'd15) || (cnt_up_down && mq == 4'd0));

  always @(posedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int seen = 0;
    for (int i = 0; i < limit && seen == 0; i++) begin
      step();
      if (done) seen = 1;
    end
    check("done_timeout", seen, 1);
  endtask

  task automatic run_sweep(input logic [3:0] s, input logic [7:0] u, input logic [7:0] dn,
                           input int limit);
    cfg_start = s; cfg_up = u; cfg_down = dn;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(limit);
    step();
  endtask

  initial begin
    mr_n = 1'b0; start = 1'b0; stuck = 1'b0;
    cfg_start = 4'd0; cfg_up = 8'd0; cfg_down = 8'd0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", cnt_load, 1);
    check("rst_en", cnt_en, 0);
    check("rst_ud", cnt_up_down, 0);
    check("rst_d", cnt_d, 0);
    check("rst_co", co_cnt, 0);
    check("rst_err", err, 0);
    mr_n = 1'b1;
    step();

    // start=1, up 3: explicit cycle-by-cycle view
    d0 = done_seen;
    cfg_start = 4'd1; cfg_up = 8'd3; cfg_down = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("a_load", cnt_load, 0);
    check("a_d", cnt_d, 1);
    check("a_en_load", cnt_en, 0);
    check("a_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_up_en", cnt_en, 1);
      check("a_up_ud", cnt_up_down, 0);
      check("a_up_ld", cnt_load, 1);
      check("a_up_q", cnt_q, 1 + i);
    end
    step();
    check("a_done", done, 1);
    check("a_busy_fin", busy, 0);
    check("a_en_fin", cnt_en, 0);
    check("a_q", cnt_q, 4);
    step();
    check("a_done_low", done, 0);
    check("a_done_cnt", done_seen - d0, 1);
    check("a_co", co_cnt, 0);
    check("a_err", err, 0);

    // 14 up 4: wraps 15->0 once
    run_sweep(4'd14, 8'd4, 8'd0, 20);
    check("b_q", cnt_q, 2);
    check("b_co", co_cnt, 1);
    check("b_err", err, 0);

    // 15 down 17: borrows at 0->15 once
    run_sweep(4'd15, 8'd0, 8'd17, 40);
    check("c_q", cnt_q, 14);
    check("c_co", co_cnt, 1);
    check("c_ud_kept", cnt_up_down, 1);
    check("c_err", err, 0);

    // zero steps: LOAD then FIN
    cfg_start = 4'd6; cfg_up = 8'd0; cfg_down = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("z_load", cnt_load, 0);
    check("z_done_early", done, 0);
    step();
    check("z_done", done, 1);
    check("z_en", cnt_en, 0);
    step();
    check("z_q", cnt_q, 6);
    check("z_co", co_cnt, 0);

    // start while busy ignored, start in FIN ignored, start after done accepted
    d0 = done_seen;
    cfg_start = 4'd5; cfg_up = 8'd30; cfg_down = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    cfg_start = 4'd9; cfg_up = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("e_busy_mid", busy, 1);
    check("e_en_mid", cnt_en, 1);
    wait_done(40);
    check("e_q_long", cnt_q, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e_fin_start", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e_restart_busy", busy, 1);
    check("e_restart_d", cnt_d, 9);
    wait_done(10);
    step();
    check("e_q_short", cnt_q, 10);
    check("e_done_cnt", done_seen - d0, 2);

    // async reset mid-UP
    cfg_start = 4'd7; cfg_up = 8'd20; cfg_down = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    d0 = done_seen;
    #2 mr_n = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_en", cnt_en, 0);
    check("r_load", cnt_load, 1);
    check("r_d", cnt_d, 0);
    check("r_done", done, 0);
    repeat (3) step();
    mr_n = 1'b1;
    repeat (25) step();
    check("r_no_done", done_seen - d0, 0);
    check("r_busy_after", busy, 0);

    // stuck q during an UP sweep
    stuck = 1'b1;
    run_sweep(4'd3, 8'd4, 8'd0, 20);
    check("g_err", err, CHK_EN);
    repeat (3) step();
    check("g_err_held", err, CHK_EN);
    stuck = 1'b0;
    cfg_start = 4'd2; cfg_up = 8'd1; cfg_down = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("g_err_clr", err, 0);
    wait_done(10);
    step();
    check("g_err_clean", err, 0);
    check("g_q", cnt_q, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
